// File: rtl/gcd_div_ci.sv
// gcd_div_ci: multi-cycle custom-instruction unit (n: 0=GCD, 1=MOD, 2=DIV, 3=COPRIME); ports clk, reset, clk_en, start, n, dataa, datab in; done, busy, result out
module gcd_div_ci #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [1:0]       n,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] result
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, G_ZERO, G_TWOS, G_ODD, G_SUB, D_CHK, D_ITER, FIN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a, b, res, rem, rem_n, q_n;
  logic [WIDTH:0] rem_sh;
  logic [CNT_W-1:0] cnt;
  logic [1:0] op;
  logic ge, last;
  // restoring divider step: a doubles as the quotient shift register
  always_comb begin
    rem_sh = {rem, a[WIDTH-1]};
    ge = rem_sh >= {1'b0, b};
    rem_n = ge ? WIDTH'(rem_sh - {1'b0, b}) : rem_sh[WIDTH-1:0];
    q_n = {a[WIDTH-2:0], ge};
    last = cnt == CNT_W'(WIDTH - 1);
  end
  always_comb begin
    state_n = state;
    case (state)
      G_ZERO:  state_n = (a == '0 || b == '0) ? FIN : G_TWOS;
      G_TWOS:  state_n = (a[0] | b[0]) ? G_ODD : G_TWOS;
      G_ODD:   state_n = a[0] ? G_SUB : G_ODD;
      G_SUB:   state_n = (b == '0) ? FIN : G_SUB;
      D_CHK:   state_n = (b == '0) ? FIN : D_ITER;
      D_ITER:  state_n = last ? FIN : D_ITER;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (start) state_n = (n[1] ^ n[0]) ? D_CHK : G_ZERO;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else if (clk_en) state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a <= '0;
      b <= '0;
      res <= '0;
      rem <= '0;
      cnt <= '0;
      op <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      result <= '0;
    end else if (clk_en) begin
      done <= 1'b0;
      if (start) begin
        a <= dataa;
        b <= datab;
        op <= n;
        res <= '0;
        rem <= '0;
        cnt <= '0;
        result <= '0;
        busy <= 1'b1;
      end else begin
        case (state)
          G_ZERO: res <= (a == '0) ? b : a;
          G_TWOS: if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            cnt <= cnt + 1'b1;
          end
          G_ODD: if (!a[0]) a <= a >> 1;
          // a stays odd; swapping keeps a <= b so the subtraction never wraps
          G_SUB: if (b == '0) res <= a << cnt;
            else if (!b[0]) b <= b >> 1;
            else if (a > b) begin
              a <= b;
              b <= a;
            end else b <= b - a;
          D_CHK: if (b == '0) res <= op[1] ? '1 : a;
          D_ITER: begin
            a <= q_n;
            rem <= rem_n;
            cnt <= cnt + 1'b1;
            if (last) res <= op[1] ? q_n : rem_n;
          end
          FIN: begin
            done <= 1'b1;
            busy <= 1'b0;
            result <= (op == 2'd3) ? WIDTH'(res == WIDTH'(1)) : res;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
